mul_dispatch: RTL
=================

MUL_DISPATCH -- requirements
Module: mul_dispatch

Interface
REQ-001 Parameters SHALL be (one per line):
- WIDTH, 32, operand width.
- DEPTH, 4, operand-pair queue depth (power of two, >=2).
- TIMEOUT, 64, maximum WIDTH-bit MUL wait cycles before abort.
REQ-002 Ports SHALL be (one per line):
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream offers operand pair.
- in_ready  output  1  queue can accept pair.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- mul_start  output  1  start pulse to MUL.
- mul_a  output  WIDTH  operand A to MUL.
- mul_b  output  WIDTH  operand B to MUL.
- mul_res  input  2*WIDTH  MUL product.
- mul_finish  input  1  MUL done indication.
- out_valid  output  1  product available downstream.
- out_ready  input  1  downstream accepts product.
- out_res  output  2*WIDTH  captured product.
- busy  output  1  state != IDLE.
- count  output  clog2(DEPTH)+1  queue occupancy.
- err  output  1  sticky timeout flag.
REQ-003 One clock; reset synchronous and active-high, ports named clk and rst; rst SHALL be shared with the MUL instance.

Function
REQ-004 Queue: DEPTH-entry FIFO of {in_a,in_b}; in_ready = (count != DEPTH); push when in_valid && in_ready.
REQ-005 in_ready SHALL depend only on count; a pop in the same cycle SHALL NOT enable a push when full.
REQ-006 Push and pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-007 FSM states IDLE, ISSUE, WAIT, HOLD; busy = (state != IDLE).
REQ-008 IDLE: count > 0 -> ISSUE; the head pair SHALL be registered into mul_a/mul_b and popped on that edge.
REQ-009 ISSUE: mul_start = 1 for exactly one cycle; timer cleared; -> WAIT unconditionally.
REQ-010 mul_a/mul_b SHALL remain stable from ISSUE until the state leaves WAIT.
REQ-011 WAIT: timer increments each cycle; mul_finish = 1 -> out_res <= mul_res, out_valid <= 1, -> HOLD.
REQ-012 WAIT: timer == TIMEOUT-1 with mul_finish = 0 -> err <= 1, pair dropped, -> IDLE; a finish in that same cycle SHALL take priority (capture, no error).
REQ-013 mul_finish SHALL be ignored outside WAIT; a level-held finish SHALL capture only once.
REQ-014 HOLD: out_valid = 1 and out_res stable until out_valid && out_ready; then out_valid <= 0, -> IDLE.
REQ-015 The queue SHALL keep accepting pushes in all states.
REQ-016 Latency: pair pushed in cycle 0 into an empty queue with FSM in IDLE -> mul_start high in cycle 2; out_valid high the cycle after mul_finish is sampled.
REQ-017 Back-to-back: the next ISSUE SHALL occur no earlier than one cycle after the HOLD handshake; at most one MUL operation SHALL be outstanding.

Reset
REQ-018 rst = 1 SHALL force state IDLE, count 0, pointers 0, mul_start 0, mul_a/mul_b 0, out_valid 0, out_res 0, err 0, timer 0, in_ready 1.
REQ-019 rst mid-operation (any state) SHALL abandon the in-flight and queued pairs; no out_valid follows.

Verification
REQ-020 Single op: push a=3, b=5 -> one mul_start pulse 2 cycles later; out_res = 0x000000000000000F, out_valid held until out_ready.
REQ-021 Extremes: a=b=0xFFFFFFFF -> out_res = 0xFFFFFFFE00000001; a=0, b=0x12345678 -> 0.
REQ-022 Fill: push 5 pairs back-to-back with MUL busy -> in_ready low after DEPTH+1 accepted (one in flight); products emerge in push order.
REQ-023 Backpressure: out_ready low 10 cycles in HOLD -> out_res stable, no new mul_start; count keeps rising to DEPTH.
REQ-024 Timeout: stub MUL never finishes -> err = 1 at cycle TIMEOUT of WAIT, FSM IDLE, next pair issued; err stays 1 until rst.
REQ-025 Reset mid-WAIT: rst for 1 cycle -> all REQ-018 values next cycle; a later mul_finish produces no out_valid.

Source files
------------

// File: rtl/mul_dispatch.sv
// Operand-pair queue feeding an external multi-cycle multiplier, one operation at a time.
// Captures each product and holds it until the downstream side accepts it.
module mul_dispatch #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_res,
    input  logic                     mul_finish,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       out_res,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [1:0]         state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0] out_res_q, out_res_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;
    logic               push, pop;

    // in_ready looks only at occupancy, so a same-cycle pop never frees a full queue
    assign in_ready = (count_q != FULL_CNT);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == IDLE) && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        out_res_d   = out_res_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    {mul_a_d, mul_b_d} = mem_q[rd_ptr_q];
                    state_d            = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                // a finish on the last allowed cycle still wins over the abort
                if (mul_finish) begin
                    out_res_d   = mul_res;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else if (timer_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_a, in_b};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            timer_q     <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_res_q   <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            out_res_q   <= out_res_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign mul_start = (state_q == ISSUE);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign busy      = (state_q != IDLE);
    assign count     = count_q;
    assign err       = err_q;

endmodule
